// File: rtl/sr_latch_driver_if.sv
// sr_latch_driver_if: request handshake and latch drive bundle (latch_q/err added under SR_READBACK_EN)
interface sr_latch_driver_if;
  logic req_valid;
  logic req_value;
  logic req_ready;
  logic S;
  logic R;
  logic enable;
  logic busy;
  logic shadow_q;
`ifdef SR_READBACK_EN
  logic latch_q;
  logic err;
  modport master(output req_valid, req_value, latch_q, input req_ready, S, R, enable, busy, shadow_q, err);
  modport slave(input req_valid, req_value, latch_q, output req_ready, S, R, enable, busy, shadow_q, err);
`else
  modport master(output req_valid, req_value, input req_ready, S, R, enable, busy, shadow_q);
  modport slave(input req_valid, req_value, output req_ready, S, R, enable, busy, shadow_q);
`endif
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: set/reset/enable pulse sequencer for a gated SR latch with shadow copy (SR_READBACK_EN adds readback check)
module sr_latch_driver #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  sr_latch_driver_if.slave bus
);
  localparam int MX = SETUP_CYCLES > PULSE_CYCLES ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt, nxt_cnt;
  logic val_r, nxt_val, sh_ld, drv;
  logic s_q, r_q, en_q, sh_q;
  // next state, down-counter and held value; S/R/enable are registered from the next state
  always_comb begin
    nxt = st;
    nxt_cnt = cnt;
    nxt_val = val_r;
    sh_ld = 1'b0;
    case (st)
      IDLE: if (bus.req_valid) begin
        nxt = SETUP;
        nxt_cnt = CW'(SETUP_CYCLES - 1);
        nxt_val = bus.req_value;
      end
      SETUP: if (cnt == '0) begin
        nxt = PULSE;
        nxt_cnt = CW'(PULSE_CYCLES - 1);
      end else nxt_cnt = cnt - 1'b1;
      PULSE: if (cnt == '0) begin
        nxt = HOLD;
        sh_ld = 1'b1;
      end else nxt_cnt = cnt - 1'b1;
      default: nxt = IDLE;
    endcase
    drv = nxt == SETUP || nxt == PULSE;
  end
  // state register and registered latch drive
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      val_r <= 1'b0;
      s_q <= 1'b0;
      r_q <= 1'b0;
      en_q <= 1'b0;
      sh_q <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= nxt_cnt;
      val_r <= nxt_val;
      s_q <= drv & nxt_val;
      r_q <= drv & ~nxt_val;
      en_q <= nxt == PULSE;
      sh_q <= sh_ld ? val_r : sh_q;
    end
  end
  assign bus.req_ready = st == IDLE;
  assign bus.busy = st != IDLE;
  assign bus.S = s_q;
  assign bus.R = r_q;
  assign bus.enable = en_q;
  assign bus.shadow_q = sh_q;
`ifdef SR_READBACK_EN
  logic err_q;
  // sticky error when the latch disagrees with the written value during HOLD
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (st == HOLD && bus.latch_q != val_r) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`endif
endmodule
